// File: rtl/drop_engine.sv
// drop_engine: BuildingDrops scene FSM, falling-block spawner and scorer.
// Optional: define SPEEDUP_EN to raise fall speed with score.
module drop_engine #(
    parameter int          SPEED     = 4,
    parameter int          SPAWN_GAP = 30,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        frame_tick,
    input  logic        btn_start,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [11:0] blocks,
    output logic [59:0] pos_blocks,
    output logic [1:0]  people,
    output logic [1:0]  scene,
    output logic [5:0]  active,
    output logic [15:0] score
);

    localparam int         NSLOT  = 6;
    localparam logic [9:0] PARK   = 10'd512;
    localparam logic [7:0] GAP_M1 = 8'(SPAWN_GAP - 1);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_RUN   = 2'd1,
        S_END   = 2'd2
    } scene_e;

    scene_e      scene_q, scene_d;
    logic [1:0]  people_q, people_d;
    logic [1:0]  lane_q [NSLOT];
    logic [1:0]  lane_d [NSLOT];
    logic [9:0]  pos_q  [NSLOT];
    logic [9:0]  pos_d  [NSLOT];
    logic [5:0]  act_q, act_d;
    logic [15:0] score_q, score_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;

    logic [4:0]  spd;
    logic        hit;
    logic [2:0]  nret;
    logic [10:0] sum;
    logic [16:0] ssum;
    logic        free;

`ifdef SPEEDUP_EN
    logic [12:0] boost;
    always_comb begin
        boost = 13'(SPEED) + {1'b0, score_q[15:4]};
        spd   = (boost > 13'd16) ? 5'd16 : boost[4:0];
    end
`else
    assign spd = 5'(SPEED);
`endif

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (act_q[i] && lane_q[i] == people_q &&
                pos_q[i] >= 10'd321 && pos_q[i] <= 10'd479)
                hit = 1'b1;
        end
    end

    always_comb begin
        scene_d  = scene_q;
        people_d = people_q;
        lane_d   = lane_q;
        pos_d    = pos_q;
        act_d    = act_q;
        score_d  = score_q;
        cnt_d    = cnt_q;
        nret     = 3'd0;
        sum      = 11'd0;
        ssum     = 17'd0;
        free     = 1'b0;
        // Fibonacci taps 16,14,13,11 in right-shift form
        lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                    lfsr_q[15:1]};

        case (scene_q)
            S_RUN: begin
                if (btn_left && !btn_right && people_q != 2'd0)
                    people_d = people_q - 2'd1;
                else if (btn_right && !btn_left && people_q != 2'd3)
                    people_d = people_q + 2'd1;

                if (frame_tick) begin
                    if (hit) begin
                        scene_d = S_END;
                    end else begin
                        for (int i = 0; i < NSLOT; i++) begin
                            if (act_q[i]) begin
                                sum = {1'b0, pos_q[i]} + {6'd0, spd};
                                if (sum >= 11'd480) begin
                                    act_d[i]  = 1'b0;
                                    pos_d[i]  = PARK;
                                    lane_d[i] = 2'd0;
                                    nret      = nret + 3'd1;
                                end else begin
                                    pos_d[i] = sum[9:0];
                                end
                            end
                        end
                        ssum    = {1'b0, score_q} + {14'd0, nret};
                        score_d = ssum[16] ? 16'hFFFF : ssum[15:0];

                        if (cnt_q == GAP_M1) begin
                            cnt_d = 8'd0;
                            free  = 1'b1;
                            for (int i = 0; i < NSLOT; i++) begin
                                if (free && !act_d[i]) begin
                                    act_d[i]  = 1'b1;
                                    pos_d[i]  = 10'd0;
                                    lane_d[i] = lfsr_q[1:0];
                                    free      = 1'b0;
                                end
                            end
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
            end
            S_END: begin
                if (btn_start) begin
                    scene_d = S_START;
                    act_d   = '0;
                    lane_d  = '{default: 2'd0};
                    pos_d   = '{default: PARK};
                end
            end
            default: begin
                // Also catches the unused encoding 3
                if (btn_start) begin
                    scene_d  = S_RUN;
                    act_d    = '0;
                    lane_d   = '{default: 2'd0};
                    pos_d    = '{default: PARK};
                    score_d  = 16'd0;
                    people_d = 2'd1;
                    cnt_d    = 8'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            scene_q  <= S_START;
            people_q <= 2'd1;
            lane_q   <= '{default: 2'd0};
            pos_q    <= '{default: PARK};
            act_q    <= '0;
            score_q  <= 16'd0;
            cnt_q    <= 8'd0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            scene_q  <= scene_d;
            people_q <= people_d;
            lane_q   <= lane_d;
            pos_q    <= pos_d;
            act_q    <= act_d;
            score_q  <= score_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
        end
    end

    always_comb begin
        blocks     = '0;
        pos_blocks = '0;
        for (int i = 0; i < NSLOT; i++) begin
            blocks[2*i +: 2]      = lane_q[i];
            pos_blocks[10*i +: 10] = pos_q[i];
        end
    end

    assign people = people_q;
    assign scene  = scene_q;
    assign active = act_q;
    assign score  = score_q;

endmodule

// File: tb/tb_drop_engine.sv
// tb_drop_engine: directed bench for drop_engine (SPEED=4, SPAWN_GAP=7).
// Spawn lanes are steered by ticking only when the LFSR model shows the wanted lane.
module tb_drop_engine;

    localparam int          SPEED = 4;
    localparam int          GAP   = 7;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam logic [59:0] ALL_PARK = {6{10'd512}};

    logic        clk = 1'b0;
    logic        resetn;
    logic        frame_tick;
    logic        btn_start;
    logic        btn_left;
    logic        btn_right;
    logic [11:0] blocks;
    logic [59:0] pos_blocks;
    logic [1:0]  people;
    logic [1:0]  scene;
    logic [5:0]  active;
    logic [15:0] score;

    logic [15:0] m;
    int n_chk  = 0;
    int n_fail = 0;
    int ticks  = 0;

    drop_engine #(
        .SPEED(SPEED),
        .SPAWN_GAP(GAP),
        .LFSR_SEED(SEED)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .frame_tick(frame_tick),
        .btn_start(btn_start),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .blocks(blocks),
        .pos_blocks(pos_blocks),
        .people(people),
        .scene(scene),
        .active(active),
        .score(score)
    );

    always #5 clk = ~clk;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11
    always @(posedge clk) begin
        if (!resetn) m <= SEED;
        else         m <= {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
    end

    function automatic logic [9:0] pos(input int i);
        return pos_blocks[10*i +: 10];
    endfunction

    task automatic press(input logic s, input logic l, input logic r);
        btn_start = s;
        btn_left  = l;
        btn_right = r;
        @(negedge clk);
        btn_start = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
    endtask

    task automatic tick(input logic [1:0] ln, input logic r);
        int k;
        k = 0;
        while (m[1:0] !== ln && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL lfsr_wait lane=%0d never reached", ln);
        end
        frame_tick = 1'b1;
        btn_right  = r;
        @(negedge clk);
        frame_tick = 1'b0;
        btn_right  = 1'b0;
        ticks++;
    endtask

    task automatic run_to(input int target, input logic [1:0] ln);
        while (ticks < target) tick(ln, 1'b0);
    endtask

    task automatic test_reset;
        n_chk++;
        if (scene !== 2'd0) begin n_fail++; $display("FAIL rst_scene got %0d want 0", scene); end
        n_chk++;
        if (people !== 2'd1) begin n_fail++; $display("FAIL rst_people got %0d want 1", people); end
        n_chk++;
        if (blocks !== 12'h000) begin n_fail++; $display("FAIL rst_blocks got %h want 000", blocks); end
        n_chk++;
        if (pos_blocks !== ALL_PARK) begin n_fail++; $display("FAIL rst_pos got %h want %h", pos_blocks, ALL_PARK); end
        n_chk++;
        if (active !== 6'h00) begin n_fail++; $display("FAIL rst_active got %h want 00", active); end
        n_chk++;
        if (score !== 16'd0) begin n_fail++; $display("FAIL rst_score got %0d want 0", score); end
        press(1'b0, 1'b1, 1'b0);
        tick(2'd3, 1'b0);
        n_chk++;
        if (people !== 2'd1) begin n_fail++; $display("FAIL start_ignore_btn got %0d want 1", people); end
        n_chk++;
        if (active !== 6'h00 || scene !== 2'd0) begin n_fail++; $display("FAIL start_ignore_tick act=%h scene=%0d want 00/0", active, scene); end
    endtask

    task automatic test_start;
        press(1'b1, 1'b0, 1'b0);
        ticks = 0;
        n_chk++;
        if (scene !== 2'd1) begin n_fail++; $display("FAIL run_scene got %0d want 1", scene); end
        n_chk++;
        if (people !== 2'd1 || active !== 6'h00 || score !== 16'd0) begin n_fail++; $display("FAIL run_entry ppl=%0d act=%h sc=%0d want 1/00/0", people, active, score); end
        n_chk++;
        if (pos_blocks !== ALL_PARK) begin n_fail++; $display("FAIL run_pos got %h want %h", pos_blocks, ALL_PARK); end
    endtask

    task automatic test_move;
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        n_chk++;
        if (people !== 2'd0) begin n_fail++; $display("FAIL move_left_sat got %0d want 0", people); end
        repeat (4) press(1'b0, 1'b0, 1'b1);
        n_chk++;
        if (people !== 2'd3) begin n_fail++; $display("FAIL move_right_sat got %0d want 3", people); end
        press(1'b0, 1'b1, 1'b1);
        n_chk++;
        if (people !== 2'd3) begin n_fail++; $display("FAIL move_both got %0d want 3", people); end
        press(1'b0, 1'b1, 1'b0);
        n_chk++;
        if (people !== 2'd2) begin n_fail++; $display("FAIL move_left got %0d want 2", people); end
        press(1'b1, 1'b0, 1'b0);
        n_chk++;
        if (scene !== 2'd1) begin n_fail++; $display("FAIL run_ignore_start got %0d want 1", scene); end
        repeat (2) press(1'b0, 1'b1, 1'b0);
        n_chk++;
        if (people !== 2'd0) begin n_fail++; $display("FAIL move_home got %0d want 0", people); end
    endtask

    task automatic test_spawn;
        run_to(6, 2'd3);
        n_chk++;
        if (active !== 6'h00) begin n_fail++; $display("FAIL spawn_early got %h want 00", active); end
        tick(2'd3, 1'b0);
        n_chk++;
        if (active !== 6'h01 || pos(0) !== 10'd0) begin n_fail++; $display("FAIL spawn_first act=%h pos0=%0d want 01/0", active, pos(0)); end
        n_chk++;
        if (blocks[1:0] !== 2'd3) begin n_fail++; $display("FAIL spawn_lane got %0d want 3", blocks[1:0]); end
        tick(2'd3, 1'b0);
        n_chk++;
        if (pos(0) !== 10'd4 || active !== 6'h01) begin n_fail++; $display("FAIL fall_step pos0=%0d act=%h want 4/01", pos(0), active); end
    endtask

    task automatic test_full;
        run_to(42, 2'd3);
        n_chk++;
        if (active !== 6'h3F || blocks !== 12'hFFF) begin n_fail++; $display("FAIL fill act=%h blk=%h want 3F/FFF", active, blocks); end
        n_chk++;
        if (pos(0) !== 10'd140 || pos(5) !== 10'd0) begin n_fail++; $display("FAIL fill_pos p0=%0d p5=%0d want 140/0", pos(0), pos(5)); end
        run_to(49, 2'd3);
        n_chk++;
        if (active !== 6'h3F || pos(0) !== 10'd168 || pos(5) !== 10'd28) begin n_fail++; $display("FAIL full_drop act=%h p0=%0d p5=%0d want 3F/168/28", active, pos(0), pos(5)); end
    endtask

    task automatic test_retire;
        run_to(126, 2'd3);
        n_chk++;
        if (pos(0) !== 10'd476 || score !== 16'd0) begin n_fail++; $display("FAIL pre_retire p0=%0d sc=%0d want 476/0", pos(0), score); end
        tick(2'd3, 1'b0);
        n_chk++;
        if (pos(0) !== 10'd512 || active !== 6'h3E) begin n_fail++; $display("FAIL retire p0=%0d act=%h want 512/3E", pos(0), active); end
        n_chk++;
        if (score !== 16'd1 || blocks !== 12'hFFC) begin n_fail++; $display("FAIL retire_score sc=%0d blk=%h want 1/FFC", score, blocks); end
        run_to(133, 2'd3);
        n_chk++;
        if (active !== 6'h3F || pos(0) !== 10'd0 || pos(1) !== 10'd476) begin n_fail++; $display("FAIL respawn act=%h p0=%0d p1=%0d want 3F/0/476", active, pos(0), pos(1)); end
    endtask

    task automatic test_end;
        repeat (3) press(1'b0, 1'b0, 1'b1);
        tick(2'd3, 1'b0);
        n_chk++;
        if (scene !== 2'd2) begin n_fail++; $display("FAIL collide_scene got %0d want 2", scene); end
        n_chk++;
        if (score !== 16'd1 || pos(1) !== 10'd476 || pos(0) !== 10'd0) begin n_fail++; $display("FAIL collide_freeze sc=%0d p1=%0d p0=%0d want 1/476/0", score, pos(1), pos(0)); end
        tick(2'd3, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        n_chk++;
        if (pos(1) !== 10'd476 || active !== 6'h3F || people !== 2'd3) begin n_fail++; $display("FAIL end_hold p1=%0d act=%h ppl=%0d want 476/3F/3", pos(1), active, people); end
        press(1'b1, 1'b0, 1'b0);
        n_chk++;
        if (scene !== 2'd0 || active !== 6'h00 || blocks !== 12'h000) begin n_fail++; $display("FAIL end_exit sc=%0d act=%h blk=%h want 0/00/000", scene, active, blocks); end
        n_chk++;
        if (pos_blocks !== ALL_PARK || score !== 16'd1) begin n_fail++; $display("FAIL end_exit_park pos=%h score=%0d want park/1", pos_blocks, score); end
        press(1'b1, 1'b0, 1'b0);
        n_chk++;
        if (scene !== 2'd1 || score !== 16'd0 || people !== 2'd1) begin n_fail++; $display("FAIL rerun sc=%0d score=%0d ppl=%0d want 1/0/1", scene, score, people); end
    endtask

    task automatic test_reset_mid_run;
        ticks = 0;
        run_to(7, 2'd3);
        n_chk++;
        if (active !== 6'h01) begin n_fail++; $display("FAIL game2_spawn got %h want 01", active); end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        n_chk++;
        if (scene !== 2'd0 || active !== 6'h00 || people !== 2'd1) begin n_fail++; $display("FAIL midrst sc=%0d act=%h ppl=%0d want 0/00/1", scene, active, people); end
        n_chk++;
        if (pos_blocks !== ALL_PARK || blocks !== 12'h000 || score !== 16'd0) begin n_fail++; $display("FAIL midrst_slots pos=%h blk=%h sc=%0d", pos_blocks, blocks, score); end
    endtask

    task automatic test_collision;
        press(1'b1, 1'b0, 1'b0);
        ticks = 0;
        run_to(6, 2'd3);
        tick(2'd1, 1'b0);
        n_chk++;
        if (blocks[1:0] !== 2'd1 || active !== 6'h01) begin n_fail++; $display("FAIL lane1_spawn lane=%0d act=%h want 1/01", blocks[1:0], active); end
        run_to(87, 2'd3);
        n_chk++;
        if (pos(0) !== 10'd320 || scene !== 2'd1) begin n_fail++; $display("FAIL at320 p0=%0d sc=%0d want 320/1", pos(0), scene); end
        tick(2'd3, 1'b0);
        n_chk++;
        if (pos(0) !== 10'd324 || scene !== 2'd1) begin n_fail++; $display("FAIL edge320 p0=%0d sc=%0d want 324/1", pos(0), scene); end
        press(1'b0, 1'b1, 1'b0);
        tick(2'd3, 1'b1);
        n_chk++;
        if (scene !== 2'd1 || pos(0) !== 10'd328 || people !== 2'd1) begin n_fail++; $display("FAIL premove sc=%0d p0=%0d ppl=%0d want 1/328/1", scene, pos(0), people); end
        tick(2'd3, 1'b0);
        n_chk++;
        if (scene !== 2'd2 || pos(0) !== 10'd328 || pos(1) !== 10'd300) begin n_fail++; $display("FAIL hit sc=%0d p0=%0d p1=%0d want 2/328/300", scene, pos(0), pos(1)); end
        tick(2'd3, 1'b0);
        n_chk++;
        if (scene !== 2'd2 || pos(0) !== 10'd328 || pos(1) !== 10'd300) begin n_fail++; $display("FAIL hit_hold sc=%0d p0=%0d p1=%0d want 2/328/300", scene, pos(0), pos(1)); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn     = 1'b0;
        frame_tick = 1'b0;
        btn_start  = 1'b0;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        test_reset;
        test_start;
        test_move;
        test_spawn;
        test_full;
        test_retire;
        test_end;
        test_reset_mid_run;
        test_collision;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/drop_engine.md
Name: drop_engine

Overview:
Game-state generator for BuildingDrops; sits directly upstream of the VGA print/render stage and drives its blocks, pos_blocks, people and scene inputs. It runs the START/RUN/END scene FSM, spawns up to 6 falling blocks into 4 lanes from an LFSR, advances them once per video frame, moves the player on button pulses, detects collisions and keeps a score.

Parameters:
SPEED, 4, rows added to each active block's position per frame_tick (1..16)
SPAWN_GAP, 30, frame_ticks between spawn attempts (1..255)
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk  input  1  system clock
resetn  input  1  synchronous active-low reset
frame_tick  input  1  one-cycle pulse per frame (from vs edge)
btn_start  input  1  one-cycle pulse, debounced
btn_left  input  1  one-cycle pulse, debounced
btn_right  input  1  one-cycle pulse, debounced
blocks  output  12  lane of slot i at [2i+1:2i]
pos_blocks  output  60  top row of slot i at [10i+9:10i]
people  output  2  player lane
scene  output  2  0=START, 1=RUN, 2=END
active  output  6  slot occupied flags
score  output  16  blocks survived

Behaviour:
- Reset (resetn=0 at clk edge): scene=0, people=1, blocks=0, every pos field=10'd512 (PARK), active=0, score=0, spawn counter=0, LFSR=LFSR_SEED. All outputs registered.
- PARK=512 is never <= a 9-bit row, so parked slots never render. Inactive slots always hold lane 0, pos PARK.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every clk in all scenes (player timing feeds randomness).
- START: btn_start -> RUN next cycle; same edge clears slots, score=0, people=1, spawn counter=0. Other buttons ignored.
- RUN, every cycle: btn_left -> people-1 saturating at 0; btn_right -> people+1 saturating at 3; both in same cycle -> no move.
- RUN, frame_tick, in this order within a single clk edge, evaluated on the current registered state:
  1. Collision: any active slot with lane==people and pos in 321..479 (overlaps rows 400..479, block height 80) -> scene=2, all slot state and score frozen; steps 2-3 skipped.
  2. Move/retire: per active slot, sum=pos+SPEED (11-bit); sum>=480 -> park slot, clear active, score+1 saturating at 16'hFFFF; else pos=sum[9:0]. Multiple retires on one tick add their count.
  3. Spawn: counter+1; when counter reaches SPAWN_GAP-1 it resets to 0 and spawns into the lowest-index slot inactive after step 2 (lane=LFSR[1:0], pos=0, active=1). No free slot -> attempt dropped, counter still resets.
- A player move and frame_tick on the same edge: collision uses the pre-move people value; the move still commits.
- END: outputs hold (blocks stay visible); btn_start -> scene=0, slots cleared; score held until next RUN entry.
- frame_tick outside RUN: ignored. Reset mid-RUN: full reset values next edge.
- scene value 3 is never produced; decoded as START if ever reached.

Optional Feature:
SPEEDUP_EN: when defined, effective speed = min(SPEED + score[15:4], 16), recomputed each tick from the registered score. When undefined, speed is constant SPEED and no extra logic is built.

Test Plan:
- Reset, then btn_start -> scene=1, people=1, active=0, all pos=512, score=0.
- SPAWN_GAP=2, SPEED=4, 2 frame_ticks -> exactly one slot 0 active, pos=0, lane=LFSR[1:0] at spawn; next tick pos=4.
- Force a block in lane 3, player in lane 0, run to retire: pos 476 + tick -> slot parked at 512, active[0]=0, score=1.
- Block in lane 1 at pos 320, people=1, tick -> pos=324 and no END; next tick -> scene=2, pos stays 324 on further ticks.
- people=0 + btn_left -> 0; people=3 + btn_right -> 3; btn_left and btn_right together -> unchanged.
- All 6 slots active at spawn time -> no change to occupied slots, counter resets; SPEEDUP_EN with score=32 -> pos step = 6.
